rv_regfile_sb: RTL and testbench
================================

// Module: rv_regfile_sb
// PURPOSE
//  Integer register file plus issue scoreboard; sits between Decode (reads/issue) and Exec
//  (writeback, consumes isExecReqWB / ExecResult). 32 x XLEN registers, x0 hardwired to zero,
//  two combinational read ports with same-cycle writeback bypass, one write port.
//  Per-register pending-write counters let Decode stall on RAW hazards against multi-cycle LSU loads.
// PARAMETERS
//  XLEN    32  register data width
//  NREG    32  number of architectural registers (address width = $clog2(NREG))
//  CNT_W   2   width of per-register pending-write counter (max outstanding = 2**CNT_W-1)
// PORTS
//  clk          in   1     clock
//  rst_n        in   1     asynchronous reset, active low
//  rs1_addr     in   5     Decode read address, port 1
//  rs2_addr     in   5     Decode read address, port 2
//  rs1_data     out  XLEN  read data port 1 (bypassed)
//  rs2_data     out  XLEN  read data port 2 (bypassed)
//  rs1_busy     out  1     rs1 has an unresolved pending write
//  rs2_busy     out  1     rs2 has an unresolved pending write
//  issue_vld    in   1     Decode issues an instruction writing issue_rd (one-cycle pulse per instr)
//  issue_rd     in   5     destination register of issued instruction
//  issue_rdy    out  1     issue_rd counter below max; issue_vld ignored when low
//  wb_vld       in   1     writeback valid (from Exec isExecReqWB)
//  wb_addr      in   5     writeback register (ExecResult.WriteCtrl.RegAddr)
//  wb_data      in   XLEN  writeback data (ExecResult.PhyRegWriteData)
//  sb_err       out  1     sticky: writeback seen to register with zero pending count
// BEHAVIOUR
//  Reset: all registers 0, all counters 0, sb_err 0; outputs follow (data 0, busy 0, issue_rdy 1).
//  Write: posedge clk with wb_vld & wb_addr!=0 -> reg[wb_addr] <= wb_data. wb_addr==0 never writes.
//  Read (combinational, 0 latency): rsN_addr==0 -> 0; else if wb_vld & wb_addr==rsN_addr -> wb_data;
//   else reg[rsN_addr]. Both ports may read the same register.
//  Counter cnt[r], r!=0: inc = issue_vld & issue_rdy & issue_rd==r; dec = wb_vld & wb_addr==r & cnt[r]!=0.
//   inc&dec same cycle -> unchanged; inc only -> +1; dec only -> -1. cnt[0] constant 0 (issue/wb to x0 ignored).
//  issue_rdy = (issue_rd==0) | (cnt[issue_rd] != 2**CNT_W-1); combinational; issue at max is dropped.
//  rsN_busy = rsN_addr!=0 & cnt[rsN_addr]!=0 & !(wb_vld & wb_addr==rsN_addr & cnt[rsN_addr]==1)
//   i.e. the final outstanding write resolving this cycle is bypassed, not a stall.
//  Issue of rd and read of same rd in same cycle: busy reflects pre-issue count (instruction order
//   is read-before-write within one instruction).
//  wb_vld & wb_addr!=0 & cnt[wb_addr]==0: data still written, counter stays 0, sb_err <= 1 (sticky
//   until reset).
//  Decode only pulses issue_vld for instructions guaranteed to reach writeback with RegEnable set;
//   no flush input.
//  Reset mid-operation: asynchronous, all state cleared immediately, pending writes forgotten.
//  Storage: flop array; no read-during-write hazard beyond bypass rule above.
// TESTING
//  1. Reset, read x5/x31 -> 0, busy 0, issue_rdy 1, sb_err 0.
//  2. issue x5; next cycle rs1=x5 -> busy 1; wb x5=0xDEADBEEF same cycle as read -> rs1_data
//     0xDEADBEEF, busy 0; following cycle reg read 0xDEADBEEF, cnt 0.
//  3. issue x7 three times (CNT_W=2) -> issue_rdy 0 on 4th, 4th dropped; three wb x7 -> busy clears
//     only on 3rd wb cycle.
//  4. Same cycle issue x9 and wb x9 with cnt=1 -> cnt stays 1, rs2=x9 busy 1 next cycle.
//  5. wb x0=0x12345678 and issue x0 -> rs1=x0 reads 0, busy 0, sb_err 0.
//  6. wb x3=0x1 with cnt[3]==0 -> reg x3=1, sb_err 1 and held; assert rst_n low mid-run -> all cleared.

Source files
------------

// File: rtl/rv_regfile_sb.sv
// Integer register file with same-cycle writeback bypass and a per-register
// pending-write scoreboard for RAW hazard stalls in Decode.
module rv_regfile_sb #(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] rs1_addr,
  input  logic [$clog2(NREG)-1:0] rs2_addr,
  output logic [XLEN-1:0]         rs1_data,
  output logic [XLEN-1:0]         rs2_data,
  output logic                    rs1_busy,
  output logic                    rs2_busy,
  input  logic                    issue_vld,
  input  logic [$clog2(NREG)-1:0] issue_rd,
  output logic                    issue_rdy,
  input  logic                    wb_vld,
  input  logic [$clog2(NREG)-1:0] wb_addr,
  input  logic [XLEN-1:0]         wb_data,
  output logic                    sb_err
);

  localparam int AW = $clog2(NREG);
  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] CONE = CNT_W'(1);

  logic [XLEN-1:0]  regs_q [NREG];
  logic [XLEN-1:0]  regs_d [NREG];
  logic [CNT_W-1:0] cnt_q  [NREG];
  logic [CNT_W-1:0] cnt_d  [NREG];
  logic             sb_err_q;
  logic             sb_err_d;

  logic wb_ok;
  logic issue_ok;

  assign wb_ok     = wb_vld & (wb_addr != '0);
  assign issue_rdy = (issue_rd == '0) | (cnt_q[issue_rd] != CMAX);
  assign issue_ok  = issue_vld & issue_rdy & (issue_rd != '0);

  always_comb begin
    rs1_data = regs_q[rs1_addr];
    if (rs1_addr == '0)
      rs1_data = '0;
    else if (wb_vld && wb_addr == rs1_addr)
      rs1_data = wb_data;
  end

  always_comb begin
    rs2_data = regs_q[rs2_addr];
    if (rs2_addr == '0)
      rs2_data = '0;
    else if (wb_vld && wb_addr == rs2_addr)
      rs2_data = wb_data;
  end

  // The last outstanding write landing this cycle is bypassed, not stalled.
  assign rs1_busy = (rs1_addr != '0)
                  & (cnt_q[rs1_addr] != '0)
                  & !(wb_vld && wb_addr == rs1_addr
                      && cnt_q[rs1_addr] == CONE);
  assign rs2_busy = (rs2_addr != '0)
                  & (cnt_q[rs2_addr] != '0)
                  & !(wb_vld && wb_addr == rs2_addr
                      && cnt_q[rs2_addr] == CONE);

  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      regs_d[r] = regs_q[r];
      cnt_d[r]  = cnt_q[r];
    end
    regs_d[0] = '0;
    cnt_d[0]  = '0;
    for (int r = 1; r < NREG; r++) begin
      logic inc;
      logic dec;
      inc = issue_ok & (issue_rd == AW'(r));
      dec = wb_ok & (wb_addr == AW'(r)) & (cnt_q[r] != '0);
      if (wb_ok && wb_addr == AW'(r))
        regs_d[r] = wb_data;
      if (inc && !dec)
        cnt_d[r] = cnt_q[r] + CONE;
      else if (dec && !inc)
        cnt_d[r] = cnt_q[r] - CONE;
    end
  end

  assign sb_err_d = sb_err_q | (wb_ok & (cnt_q[wb_addr] == '0));
  assign sb_err   = sb_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        regs_q[r] <= '0;
        cnt_q[r]  <= '0;
      end
      sb_err_q <= 1'b0;
    end else begin
      regs_q   <= regs_d;
      cnt_q    <= cnt_d;
      sb_err_q <= sb_err_d;
    end
  end

endmodule

// File: tb/tb_rv_regfile_sb.sv
// Bench for rv_regfile_sb: directed vector table, then random traffic
// checked against a pending-write queue model.
module tb_rv_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  rs1_addr = '0, rs2_addr = '0;
  logic [31:0] rs1_data, rs2_data;
  logic        rs1_busy, rs2_busy;
  logic        issue_vld = 1'b0;
  logic [4:0]  issue_rd = '0;
  logic        issue_rdy;
  logic        wb_vld = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        sb_err;

  int n_cmp = 0;
  int n_bad = 0;

  rv_regfile_sb dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .issue_vld(issue_vld), .issue_rd(issue_rd),
    .issue_rdy(issue_rdy),
    .wb_vld(wb_vld), .wb_addr(wb_addr), .wb_data(wb_data),
    .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          iv;
    logic [4:0]  ird;
    bit          wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  a1, a2;
    logic [31:0] e1, e2;
    bit          eb1, eb2, erdy, eerr;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    bit rst, bit iv, logic [4:0] ird,
    bit wv, logic [4:0] wa, logic [31:0] wd,
    logic [4:0] a1, logic [4:0] a2,
    logic [31:0] e1, logic [31:0] e2,
    bit eb1, bit eb2, bit erdy, bit eerr);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ird = ird;
    v.wv = wv; v.wa = wa; v.wd = wd;
    v.a1 = a1; v.a2 = a2; v.e1 = e1; v.e2 = e2;
    v.eb1 = eb1; v.eb2 = eb2; v.erdy = erdy; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Reference model: contents plus a list of outstanding writes per register.
  logic [31:0] m_reg [32];
  int          m_pend [32][$];
  bit          m_err;

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin
      m_reg[r] = '0;
      m_pend[r].delete();
    end
    m_err = 1'b0;
  endfunction

  function automatic logic [31:0] m_read(logic [4:0] a);
    if (a == 0) return '0;
    if (wb_vld && wb_addr == a) return wb_data;
    return m_reg[a];
  endfunction

  function automatic bit m_busy(logic [4:0] a);
    int n;
    if (a == 0) return 1'b0;
    n = m_pend[a].size();
    if (wb_vld && wb_addr == a) n = n - 1;
    return n > 0;
  endfunction

  function automatic bit m_rdy();
    return issue_rd == 0 || m_pend[issue_rd].size() < 3;
  endfunction

  function automatic void m_clock(int tag);
    bit acc;
    bit had;
    acc = issue_vld && issue_rd != 0 && m_pend[issue_rd].size() < 3;
    had = wb_vld && wb_addr != 0 && m_pend[wb_addr].size() != 0;
    if (wb_vld && wb_addr != 0) begin
      m_reg[wb_addr] = wb_data;
      if (had) void'(m_pend[wb_addr].pop_front());
      else m_err = 1'b1;
    end
    if (acc) m_pend[issue_rd].push_back(tag);
  endfunction

  task automatic drive(vec_t v);
    rst_n = !v.rst;
    issue_vld = v.iv; issue_rd = v.ird;
    wb_vld = v.wv; wb_addr = v.wa; wb_data = v.wd;
    rs1_addr = v.a1; rs2_addr = v.a2;
  endtask

  initial begin
    // reset view
    tbl.push_back(mk(0,0,0, 0,0,0, 5,31, 0,0, 0,0,1,0));
    // issue x5, stall, bypassed resolve
    tbl.push_back(mk(0,1,5, 0,0,0, 5,0, 0,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 5,5, 0,0, 1,1,1,0));
    tbl.push_back(mk(0,0,5, 1,5,32'hDEADBEEF, 5,5,
                     32'hDEADBEEF,32'hDEADBEEF, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 5,0, 32'hDEADBEEF,0, 0,0,1,0));
    // fill x7 to max, fourth issue dropped
    tbl.push_back(mk(0,1,7, 0,0,0, 7,0, 0,0, 0,0,1,0));
    tbl.push_back(mk(0,1,7, 0,0,0, 7,0, 0,0, 1,0,1,0));
    tbl.push_back(mk(0,1,7, 0,0,0, 7,0, 0,0, 1,0,1,0));
    tbl.push_back(mk(0,1,7, 0,0,0, 7,0, 0,0, 1,0,0,0));
    tbl.push_back(mk(0,0,7, 1,7,32'h11, 7,0, 32'h11,0, 1,0,0,0));
    tbl.push_back(mk(0,0,0, 1,7,32'h22, 7,0, 32'h22,0, 1,0,1,0));
    tbl.push_back(mk(0,0,0, 1,7,32'h33, 7,0, 32'h33,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 7,7, 32'h33,32'h33, 0,0,1,0));
    // simultaneous issue and wb of x9
    tbl.push_back(mk(0,1,9, 0,0,0, 0,9, 0,0, 0,0,1,0));
    tbl.push_back(mk(0,1,9, 1,9,32'h99, 0,9, 0,32'h99, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,9, 0,32'h99, 0,1,1,0));
    tbl.push_back(mk(0,0,0, 1,9,32'hAA, 0,9, 0,32'hAA, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,9, 0,32'hAA, 0,0,1,0));
    // x0 is inert
    tbl.push_back(mk(0,1,0, 1,0,32'h12345678, 0,0, 0,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0,1,0));
    // unexpected wb sets sticky error; async reset clears all
    tbl.push_back(mk(0,0,0, 1,3,32'h1, 3,0, 32'h1,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 3,0, 32'h1,0, 0,0,1,1));
    tbl.push_back(mk(0,1,5, 0,0,0, 3,5, 32'h1,32'hDEADBEEF, 0,0,1,1));
    tbl.push_back(mk(0,0,0, 0,0,0, 3,5, 32'h1,32'hDEADBEEF, 0,1,1,1));
    tbl.push_back(mk(1,0,5, 0,0,0, 3,5, 0,0, 0,0,1,0));
    tbl.push_back(mk(0,0,0, 0,0,0, 7,9, 0,0, 0,0,1,0));

    #12;
    @(posedge clk); #1;
    foreach (tbl[i]) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("v%0d rs1_data", i), rs1_data, tbl[i].e1);
      chk($sformatf("v%0d rs2_data", i), rs2_data, tbl[i].e2);
      chk($sformatf("v%0d rs1_busy", i), 32'(rs1_busy), 32'(tbl[i].eb1));
      chk($sformatf("v%0d rs2_busy", i), 32'(rs2_busy), 32'(tbl[i].eb2));
      chk($sformatf("v%0d issue_rdy", i), 32'(issue_rdy), 32'(tbl[i].erdy));
      chk($sformatf("v%0d sb_err", i), 32'(sb_err), 32'(tbl[i].eerr));
      @(posedge clk); #1;
    end

    // random traffic against the model, with one mid-run reset
    rst_n = 1'b0; issue_vld = 0; wb_vld = 0;
    #1;
    m_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] cand[$];
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        m_reset();
        chk("mid reset sb_err", 32'(sb_err), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
      end
      issue_vld = ($urandom_range(0, 99) < 45);
      issue_rd  = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) issue_rd = 5'($urandom);
      wb_vld  = ($urandom_range(0, 99) < 45);
      wb_data = $urandom;
      cand.delete();
      for (int r = 1; r < 32; r++)
        if (m_pend[r].size() != 0) cand.push_back(5'(r));
      if (cand.size() != 0 && $urandom_range(0, 99) < 97)
        wb_addr = cand[$urandom_range(0, cand.size() - 1)];
      else
        wb_addr = 5'($urandom_range(0, 7));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = ($urandom_range(0, 3) == 0) ? wb_addr
                                            : 5'($urandom_range(0, 7));
      #1;
      chk("rnd rs1_data", rs1_data, m_read(rs1_addr));
      chk("rnd rs2_data", rs2_data, m_read(rs2_addr));
      chk("rnd rs1_busy", 32'(rs1_busy), 32'(m_busy(rs1_addr)));
      chk("rnd rs2_busy", 32'(rs2_busy), 32'(m_busy(rs2_addr)));
      chk("rnd issue_rdy", 32'(issue_rdy), 32'(m_rdy()));
      chk("rnd sb_err", 32'(sb_err), 32'(m_err));
      @(posedge clk);
      m_clock(c);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
